// File: rtl/ca_pkg.sv
// Shared state encoding and default widths for the cache line burst adaptor.
// Optional timeout logic is enabled by defining CA_TIMEOUT_EN.
package ca_pkg;

    localparam int CA_LINE_W = 256;
    localparam int CA_BUS_W  = 32;
    localparam int CA_ADDR_W = 32;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        WRITE,
        DONE
    } ca_state_e;

endpackage

// File: rtl/ca_beat_counter.sv
// Beat index within a line burst, with a flag for the final beat.
module ca_beat_counter #(
    parameter int BEATS = 8,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] beat,
    output logic             last
);

    logic [CNT_W-1:0] beat_q, beat_d;

    always_comb begin
        beat_d = beat_q;
        if (clr) begin
            beat_d = '0;
        end else if (inc) begin
            beat_d = last ? '0 : beat_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_q <= '0;
        end else begin
            beat_q <= beat_d;
        end
    end

    assign beat = beat_q;
    assign last = (beat_q == CNT_W'(BEATS - 1));

endmodule

// File: rtl/cacheline_burst_adaptor.sv
// Splits cache line fills/write-backs into BUS_W-wide memory beats.
// Define CA_TIMEOUT_EN to abort a burst whose beat waits TIMEOUT_CYC cycles.
module cacheline_burst_adaptor
    import ca_pkg::*;
#(
    parameter int LINE_W      = CA_LINE_W,
    parameter int BUS_W       = CA_BUS_W,
    parameter int ADDR_W      = CA_ADDR_W,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 line_read,
    input  logic                 line_write,
    input  logic [ADDR_W-1:0]    line_addr,
    input  logic [LINE_W-1:0]    line_wdata,
    output logic [LINE_W-1:0]    line_rdata,
    output logic                 line_resp,
    output logic                 line_err,
    output logic                 mem_read,
    output logic                 mem_write,
    output logic [ADDR_W-1:0]    mem_addr,
    output logic [BUS_W-1:0]     mem_wdata,
    output logic [BUS_W/8-1:0]   mem_byte_enable,
    input  logic [BUS_W-1:0]     mem_rdata,
    input  logic                 mem_resp
);

    localparam int BEATS = LINE_W / BUS_W;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int BYTES = BUS_W / 8;
    localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'(LINE_W / 8 - 1);

    ca_state_e         state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [LINE_W-1:0] wdata_q, wdata_d;
    logic [LINE_W-1:0] rdata_q, rdata_d;
    logic [CNT_W-1:0]  beat;
    logic              last;
    logic              busy;
    logic              beat_done;
    logic              expired;

    assign busy      = (state_q == READ) || (state_q == WRITE);
    assign beat_done = busy && mem_resp;

    ca_beat_counter #(
        .BEATS (BEATS),
        .CNT_W (CNT_W)
    ) u_beat (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (state_q == IDLE),
        .inc   (beat_done),
        .beat  (beat),
        .last  (last)
    );

`ifdef CA_TIMEOUT_EN
    localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);

    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic             err_q, err_d;

    // Counter restarts whenever a beat completes, so it measures one beat.
    always_comb begin
        tmr_d   = '0;
        expired = 1'b0;
        err_d   = err_q;
        if (busy && !mem_resp) begin
            tmr_d   = tmr_q + TMR_W'(1);
            expired = (tmr_q == TMR_W'(TIMEOUT_CYC - 1));
        end
        if (expired) begin
            err_d = 1'b1;
        end else if (state_q == DONE) begin
            err_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmr_q <= '0;
            err_q <= 1'b0;
        end else begin
            tmr_q <= tmr_d;
            err_q <= err_d;
        end
    end

    assign line_err = (state_q == DONE) && err_q;
`else
    logic unused_tmo;

    assign unused_tmo = (TIMEOUT_CYC == 0);
    assign expired    = 1'b0;
    assign line_err   = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        unique case (state_q)
            IDLE: begin
                if (line_write) begin
                    base_d  = line_addr & ~OFF_MASK;
                    wdata_d = line_wdata;
                    state_d = WRITE;
                end else if (line_read) begin
                    base_d  = line_addr & ~OFF_MASK;
                    state_d = READ;
                end
            end
            READ: begin
                if (mem_resp) begin
                    rdata_d[beat*BUS_W +: BUS_W] = mem_rdata;
                    if (last) begin
                        state_d = DONE;
                    end
                end else if (expired) begin
                    state_d = DONE;
                end
            end
            WRITE: begin
                if (mem_resp) begin
                    if (last) begin
                        state_d = DONE;
                    end
                end else if (expired) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            base_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    assign mem_read        = (state_q == READ);
    assign mem_write       = (state_q == WRITE);
    assign mem_addr        = busy ? base_q + ADDR_W'(beat) * ADDR_W'(BYTES) : '0;
    assign mem_wdata       = mem_write ? wdata_q[beat*BUS_W +: BUS_W] : '0;
    assign mem_byte_enable = {BYTES{mem_write}};
    assign line_rdata      = rdata_q;
    assign line_resp       = (state_q == DONE);

endmodule
